// File: rtl/i2c_master_seq_ctrl.sv
// i2c_master_seq_ctrl: command-driven I2C master sequencer (START/WRITE/READ/STOP).
// Params: DIV = clk cycles per SCL quarter (SCL period 4*DIV), CNT_W derived.
// Ports: clk, rst (sync, active-high); cmd_valid/cmd_ready/cmd_op/cmd_data/cmd_nack;
//   rsp_valid/rsp_data/rsp_err, busy; scl_out/sda_io drives (1 = release), scl_in/sda_in.
// Optional macro I2C_CLK_STRETCH_EN: stall the quarter timer while a slave holds SCL low.
module i2c_master_seq_ctrl #(
    parameter int DIV   = 4,
    parameter int CNT_W = $clog2(DIV)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [7:0] cmd_data,
    input  logic       cmd_nack,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       busy,
    output logic       scl_out,
    input  logic       scl_in,
    output logic       sda_io,
    input  logic       sda_in
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RSP} state_t;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [3:0]       bit_q, bit_d;
    logic [1:0]       op_q, op_d;
    logic [7:0]       sh_q, sh_d;
    logic             nack_q, nack_d;
    logic             ack_q, ack_d;
    logic             nobus_q, nobus_d;
    logic             bus_q, bus_d;
    logic             scl_q, scl_d;
    logic             sda_q, sda_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q, rsp_err_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic             stall;
    logic             tick;
    logic             tx_bit;

`ifdef I2C_CLK_STRETCH_EN
    // We released SCL but the line is still low: a slave is stretching.
    assign stall = scl_q && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign stall = 1'b0;
`endif

    assign tick = !stall && (cnt_q == CNT_MAX);

    // sh_q doubles as the WRITE transmit shifter and the READ receive shifter.
    always_comb begin
        if (bit_q == 4'd8) begin
            tx_bit = (op_q == OP_WRITE) ? 1'b1 : nack_q;
        end else begin
            tx_bit = (op_q == OP_WRITE) ? sh_q[7] : 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        qtr_d       = qtr_q;
        bit_d       = bit_q;
        op_d        = op_q;
        sh_d        = sh_q;
        nack_d      = nack_q;
        ack_d       = ack_q;
        nobus_d     = nobus_q;
        bus_d       = bus_q;
        scl_d       = scl_q;
        sda_d       = sda_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        if (state_q != S_IDLE && !stall) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick) qtr_d = qtr_q + 2'd1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    sh_d    = cmd_data;
                    nack_d  = cmd_nack;
                    ack_d   = 1'b0;
                    nobus_d = 1'b0;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    bit_d   = 4'd0;
                    if (cmd_op == OP_START) begin
                        state_d = S_START;
                    end else if (cmd_op == OP_STOP) begin
                        state_d = S_STOP;
                    end else if (bus_q) begin
                        state_d = S_BIT;
                    end else begin
                        nobus_d = 1'b1;
                        state_d = S_RSP;
                    end
                end
            end
            S_START: begin
                scl_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                sda_d = (qtr_q == 2'd0) || (qtr_q == 2'd1);
                if (tick && qtr_q == 2'd3) begin
                    bus_d   = 1'b1;
                    state_d = S_RSP;
                end
            end
            S_BIT: begin
                scl_d = (qtr_q == 2'd1) || (qtr_q == 2'd2);
                if (qtr_q == 2'd0) sda_d = tx_bit;
                if (tick && qtr_q == 2'd2) begin
                    if (bit_q == 4'd8) ack_d = sda_in;
                    else sh_d = {sh_q[6:0], sda_in};
                end
                if (tick && qtr_q == 2'd3) begin
                    if (bit_q == 4'd8) state_d = S_RSP;
                    else bit_d = bit_q + 4'd1;
                end
            end
            S_STOP: begin
                scl_d = (qtr_q != 2'd0);
                sda_d = (qtr_q == 2'd2) || (qtr_q == 2'd3);
                if (tick && qtr_q == 2'd3) begin
                    bus_d   = 1'b0;
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = nobus_q || (op_q == OP_WRITE && ack_q);
                if (op_q == OP_READ && !nobus_q) rsp_data_d = sh_q;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            qtr_q       <= 2'd0;
            bit_q       <= 4'd0;
            op_q        <= OP_START;
            sh_q        <= 8'h00;
            nack_q      <= 1'b0;
            ack_q       <= 1'b0;
            nobus_q     <= 1'b0;
            bus_q       <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            qtr_q       <= qtr_d;
            bit_q       <= bit_d;
            op_q        <= op_d;
            sh_q        <= sh_d;
            nack_q      <= nack_d;
            ack_q       <= ack_d;
            nobus_q     <= nobus_d;
            bus_q       <= bus_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign scl_out   = scl_q;
    assign sda_io    = sda_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_i2c_master_seq_ctrl.sv
// tb_i2c_master_seq_ctrl: directed bench for i2c_master_seq_ctrl with a small
// slave model on the open-drain lines and a response scoreboard.
module tb_i2c_master_seq_ctrl;
    localparam int DIV = 4;
`ifdef I2C_CLK_STRETCH_EN
    localparam int STRETCH = 20;
`else
    localparam int STRETCH = 0;
`endif
    localparam int T_SS   = 4 * DIV + 1;
    localparam int T_BYTE = 36 * DIV + 1;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_STOP  = 2'b11;

    typedef struct {
        logic [7:0] data;
        logic       err;
        int         lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [7:0] cmd_data;
    logic       cmd_nack;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic       busy;
    logic       scl_out;
    logic       scl_in;
    logic       sda_io;
    logic       sda_in;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    i2c_master_seq_ctrl #(.DIV(DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .cmd_nack  (cmd_nack),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .scl_out   (scl_out),
        .scl_in    (scl_in),
        .sda_io    (sda_io),
        .sda_in    (sda_in)
    );

    // Slave model: mode 0 released, 1 ACKs a written byte, 2 sends slave_byte.
    int         slave_mode = 0;
    logic [7:0] slave_byte = 8'h00;
    logic       stretch_en = 1'b0;
    int         fall_cnt = 0;
    int         rise_cnt = 0;
    int         stretch_left = 0;
    logic [1:0] cur_op = OP_STOP;
    logic       scl_prev = 1'b1;
    logic       sda_prev = 1'b1;
    logic       viol = 1'b0;
    logic       obs_bits [0:15];
    logic       slave_sda;
    logic       stretch_pull;

    always_comb begin
        slave_sda = 1'b1;
        if (slave_mode == 1 && fall_cnt == 8) slave_sda = 1'b0;
        if (slave_mode == 2 && fall_cnt < 8) slave_sda = slave_byte[3'(7 - fall_cnt)];
    end

    assign stretch_pull = (stretch_left != 0) && (fall_cnt == 3) && (cur_op == OP_WRITE);
    assign scl_in = scl_out & ~stretch_pull;
    assign sda_in = sda_io & slave_sda;

    // Line monitor on the falling clock edge, away from DUT updates.
    always @(negedge clk) begin
        if (rst) begin
            cur_op <= OP_STOP;
        end else if (cmd_valid && cmd_ready) begin
            fall_cnt <= 0;
            rise_cnt <= 0;
            cur_op   <= cmd_op;
        end else begin
            if (scl_prev && !scl_out) fall_cnt <= fall_cnt + 1;
            if (!scl_prev && scl_out) begin
                if (rise_cnt < 16) obs_bits[rise_cnt] <= sda_io;
                rise_cnt <= rise_cnt + 1;
            end
            if (scl_prev && scl_out && (sda_io != sda_prev) &&
                (cur_op == OP_WRITE || cur_op == OP_READ)) viol <= 1'b1;
        end
        scl_prev <= scl_out;
        sda_prev <= sda_io;
    end

    // One stretched cycle per clock edge the master sees SCL held low.
    always @(posedge clk) begin
        if (cmd_valid && cmd_ready) stretch_left <= stretch_en ? 20 : 0;
        else if (stretch_pull && scl_out) stretch_left <= stretch_left - 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic reset_chk(input string tag);
        chk({tag, "_scl"}, 32'(scl_out), 32'd1);
        chk({tag, "_sda"}, 32'(sda_io), 32'd1);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
        chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] data,
                           input logic nack, input logic [7:0] exp_data,
                           input logic exp_err, input int exp_lat);
        exp_t e;
        exp_t got;
        int   cyc;
        e.data = exp_data;
        e.err  = exp_err;
        e.lat  = exp_lat;
        sb.push_back(e);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        cmd_nack  = nack;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1 cyc++;
        end while (!rsp_valid && cyc < 400);
        got = sb.pop_front();
        chk({tag, "_lat"}, 32'(cyc), 32'(got.lat));
        chk({tag, "_data"}, 32'(rsp_data), 32'(got.data));
        chk({tag, "_err"}, 32'(rsp_err), 32'(got.err));
        @(posedge clk);
        #1 chk({tag, "_pulse"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [7:0] wb;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = OP_START;
        cmd_data  = 8'h00;
        cmd_nack  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_chk("reset");

        run_cmd("rd_nobus", OP_READ, 8'h00, 1'b0, 8'h00, 1'b1, 1);
        chk("rd_nobus_scl", 32'(scl_out), 32'd1);
        chk("rd_nobus_sda", 32'(sda_io), 32'd1);
        chk("rd_nobus_rises", 32'(rise_cnt), 32'd0);

        run_cmd("start1", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, T_SS);
        slave_mode = 1;
        wb = 8'hA5;
        run_cmd("wr_a5", OP_WRITE, wb, 1'b0, 8'h00, 1'b0, T_BYTE);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("wr_a5_bit%0d", i), 32'(obs_bits[i]), 32'(wb[7 - i]));
        end
        chk("wr_a5_bit8_rel", 32'(obs_bits[8]), 32'd1);
        chk("wr_a5_rises", 32'(rise_cnt), 32'd9);
        slave_mode = 0;
        run_cmd("stop1", OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, T_SS);
        chk("stop1_scl", 32'(scl_out), 32'd1);
        chk("stop1_sda", 32'(sda_io), 32'd1);

        run_cmd("start2", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, T_SS);
        run_cmd("wr_3c_nack", OP_WRITE, 8'h3C, 1'b0, 8'h00, 1'b1, T_BYTE);
        run_cmd("stop2", OP_STOP, 8'h00, 1'b0, 8'h00, 1'b0, T_SS);

        run_cmd("start3", OP_START, 8'h00, 1'b0, 8'h00, 1'b0, T_SS);
        slave_mode = 2;
        slave_byte = 8'h5A;
        run_cmd("rd_5a", OP_READ, 8'h00, 1'b1, 8'h5A, 1'b0, T_BYTE);
        chk("rd_5a_bit8_nack", 32'(obs_bits[8]), 32'd1);
        chk("rd_5a_rises", 32'(rise_cnt), 32'd9);
        slave_mode = 0;
        run_cmd("stop3", OP_STOP, 8'h00, 1'b0, 8'h5A, 1'b0, T_SS);

        run_cmd("start4", OP_START, 8'h00, 1'b0, 8'h5A, 1'b0, T_SS);
        slave_mode = 1;
        stretch_en = 1'b1;
        run_cmd("wr_stretch", OP_WRITE, 8'h81, 1'b0, 8'h5A, 1'b0, T_BYTE + STRETCH);
        stretch_en = 1'b0;
        slave_mode = 0;
        run_cmd("stop4", OP_STOP, 8'h00, 1'b0, 8'h5A, 1'b0, T_SS);

        run_cmd("start5", OP_START, 8'h00, 1'b0, 8'h5A, 1'b0, T_SS);
        cmd_valid = 1'b1;
        cmd_op    = OP_WRITE;
        cmd_data  = 8'hFF;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        repeat (50) @(posedge clk);
        #1 chk("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        reset_chk("mid_reset");

        run_cmd("wr_after_rst", OP_WRITE, 8'h12, 1'b0, 8'h00, 1'b1, 1);
        chk("sda_stable_scl_high", 32'(viol), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
